// File: rtl/ex_muldiv_pkg.sv
// Shared definitions for the EX-stage multiply/divide unit: op codes, FSM states,
// divide-by-zero quotient and the signed-op decode.
package ex_muldiv_pkg;

    localparam int MD_DATA_W = 32;
    localparam int MD_CNT_W  = 5;

    typedef enum logic [1:0] {
        MD_MULT  = 2'd0,
        MD_MULTU = 2'd1,
        MD_DIV   = 2'd2,
        MD_DIVU  = 2'd3
    } md_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIN  = 2'd2
    } md_state_t;

    localparam logic [MD_DATA_W-1:0] MD_DIV0_Q = '1;

    function automatic logic md_is_signed(input md_op_t op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

    function automatic logic md_is_div(input md_op_t op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/md_iter_dp.sv
// One iteration of the multiply/divide datapath over {acc, work}; purely combinational.
// Multiply: conditional add then right shift. Divide: restoring trial subtract, one quotient bit.
module md_iter_dp #(
    parameter int data_size = 32
) (
    input  logic                 i_is_div,
    input  logic [data_size-1:0] i_acc,
    input  logic [data_size-1:0] i_work,
    input  logic [data_size-1:0] i_opnd,
    output logic [data_size-1:0] o_acc,
    output logic [data_size-1:0] o_work
);

    logic [data_size:0]   w_sum;
    logic [data_size:0]   w_shift;
    logic [data_size-1:0] w_diff;
    logic                 w_ge;

    assign w_sum   = {1'b0, i_acc} + {1'b0, i_opnd};
    assign w_shift = {i_acc, i_work[data_size-1]};
    assign w_ge    = (w_shift >= {1'b0, i_opnd});
    // Only the low bits of the difference survive: a successful trial leaves it below the divisor.
    assign w_diff  = w_shift[data_size-1:0] - i_opnd;

    always_comb begin
        o_acc  = i_acc;
        o_work = i_work;
        if (i_is_div) begin
            o_acc  = w_ge ? w_diff : w_shift[data_size-1:0];
            o_work = {i_work[data_size-2:0], w_ge};
        end else if (i_work[0]) begin
            o_acc  = w_sum[data_size:1];
            o_work = {w_sum[0], i_work[data_size-1:1]};
        end else begin
            o_acc  = {1'b0, i_acc[data_size-1:1]};
            o_work = {i_acc[0], i_work[data_size-1:1]};
        end
    end

endmodule

// File: rtl/ex_muldiv.sv
// EX-stage iterative MULT/MULTU/DIV/DIVU owning HI/LO; 33 edges from accept to result
// (divide-by-zero: 1), MD_stall holds the front of the pipe until the MD_done cycle.
module ex_muldiv
    import ex_muldiv_pkg::*;
#(
    parameter int data_size = 32,
    parameter int cnt_size  = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 EX_MD_start,
    input  logic [1:0]           EX_MD_op,
    input  logic                 EX_MtHi,
    input  logic                 EX_MtLo,
    input  logic [data_size-1:0] EX_Rs_data,
    input  logic [data_size-1:0] EX_Rt_data,
    output logic [data_size-1:0] MD_HI,
    output logic [data_size-1:0] MD_LO,
    output logic                 MD_stall,
    output logic                 MD_done
);

    md_state_t              r_state;
    md_state_t              w_state_nxt;
    md_op_t                 r_op;
    logic [cnt_size-1:0]    r_cnt;
    logic                   r_sign_q;
    logic                   r_sign_r;
    logic [data_size-1:0]   r_acc;
    logic [data_size-1:0]   r_work;
    logic [data_size-1:0]   r_opnd;
    logic [data_size-1:0]   r_hi;
    logic [data_size-1:0]   r_lo;
    logic                   r_done;

    md_op_t                 w_op;
    logic                   w_is_div_in;
    logic                   w_rs_neg;
    logic                   w_rt_neg;
    logic [data_size-1:0]   w_rs_abs;
    logic [data_size-1:0]   w_rt_abs;
    logic                   w_accept;
    logic                   w_div0;
    logic                   w_is_div;
    logic [data_size-1:0]   w_dp_acc;
    logic [data_size-1:0]   w_dp_work;
    logic [2*data_size-1:0] w_prod;
    logic [2*data_size-1:0] w_prod_s;
    logic [data_size-1:0]   w_quo;
    logic [data_size-1:0]   w_rem;

    assign w_op        = md_op_t'(EX_MD_op);
    assign w_is_div_in = md_is_div(w_op);
    assign w_rs_neg    = md_is_signed(w_op) & EX_Rs_data[data_size-1];
    assign w_rt_neg    = md_is_signed(w_op) & EX_Rt_data[data_size-1];
    assign w_rs_abs    = w_rs_neg ? -EX_Rs_data : EX_Rs_data;
    assign w_rt_abs    = w_rt_neg ? -EX_Rt_data : EX_Rt_data;
    assign w_accept    = (r_state == ST_IDLE) & EX_MD_start & ~r_done;
    assign w_div0      = w_is_div_in & (EX_Rt_data == '0);
    assign w_is_div    = md_is_div(r_op);

    assign w_prod   = {r_acc, r_work};
    assign w_prod_s = r_sign_q ? -w_prod : w_prod;
    assign w_quo    = r_sign_q ? -r_work : r_work;
    assign w_rem    = r_sign_r ? -r_acc : r_acc;

    md_iter_dp #(.data_size(data_size)) u_iter_dp (
        .i_is_div (w_is_div),
        .i_acc    (r_acc),
        .i_work   (r_work),
        .i_opnd   (r_opnd),
        .o_acc    (w_dp_acc),
        .o_work   (w_dp_work)
    );

    always_ff @(negedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        MD_stall    = (r_state != ST_IDLE) | (EX_MD_start & ~r_done);
        case (r_state)
            ST_IDLE: if (w_accept) w_state_nxt = w_div0 ? ST_FIN : ST_CALC;
            ST_CALC: if (r_cnt == '1) w_state_nxt = ST_FIN;
            ST_FIN:  w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            r_op     <= MD_MULT;
            r_cnt    <= '0;
            r_sign_q <= 1'b0;
            r_sign_r <= 1'b0;
            r_acc    <= '0;
            r_work   <= '0;
            r_opnd   <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= (r_state == ST_FIN);
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_op     <= w_op;
                        r_cnt    <= '0;
                        // Divide-by-zero keeps the all-ones quotient unsigned; |Rs| regains its sign via sign_r.
                        r_sign_q <= w_div0 ? 1'b0 : (w_rs_neg ^ w_rt_neg);
                        r_sign_r <= w_rs_neg;
                        if (w_is_div_in) begin
                            r_acc  <= w_div0 ? w_rs_abs : '0;
                            r_work <= w_div0 ? data_size'(MD_DIV0_Q) : w_rs_abs;
                            r_opnd <= w_rt_abs;
                        end else begin
                            r_acc  <= '0;
                            r_work <= w_rt_abs;
                            r_opnd <= w_rs_abs;
                        end
                    end else if (!EX_MD_start) begin
                        if (EX_MtHi) r_hi <= EX_Rs_data;
                        if (EX_MtLo) r_lo <= EX_Rs_data;
                    end
                end
                ST_CALC: begin
                    r_acc  <= w_dp_acc;
                    r_work <= w_dp_work;
                    r_cnt  <= r_cnt + 1'b1;
                end
                ST_FIN: begin
                    if (w_is_div) begin
                        r_lo <= w_quo;
                        r_hi <= w_rem;
                    end else begin
                        r_hi <= w_prod_s[2*data_size-1:data_size];
                        r_lo <= w_prod_s[data_size-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    assign MD_HI   = r_hi;
    assign MD_LO   = r_lo;
    assign MD_done = r_done;

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed bench for ex_muldiv: inputs change and outputs are sampled around posedge,
// away from the negedge on which the unit updates.
module tb_ex_muldiv;

    logic        clk;
    logic        rst;
    logic        EX_MD_start;
    logic [1:0]  EX_MD_op;
    logic        EX_MtHi;
    logic        EX_MtLo;
    logic [31:0] EX_Rs_data;
    logic [31:0] EX_Rt_data;
    logic [31:0] MD_HI;
    logic [31:0] MD_LO;
    logic        MD_stall;
    logic        MD_done;

    int total = 0;
    int bad   = 0;

    ex_muldiv dut (
        .clk         (clk),
        .rst         (rst),
        .EX_MD_start (EX_MD_start),
        .EX_MD_op    (EX_MD_op),
        .EX_MtHi     (EX_MtHi),
        .EX_MtLo     (EX_MtLo),
        .EX_Rs_data  (EX_Rs_data),
        .EX_Rt_data  (EX_Rt_data),
        .MD_HI       (MD_HI),
        .MD_LO       (MD_LO),
        .MD_stall    (MD_stall),
        .MD_done     (MD_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Issues one op and returns in its MD_done cycle (start already dropped, no edge taken yet).
    task automatic run_op(input logic [1:0] op, input logic [31:0] rs, input logic [31:0] rt,
                          output int stalls, output bit seen, output bit stall_at_done);
        stalls = 0;
        seen = 1'b0;
        stall_at_done = 1'b1;
        @(posedge clk);
        EX_MD_op = op;
        EX_Rs_data = rs;
        EX_Rt_data = rt;
        EX_MD_start = 1'b1;
        #1;
        for (int i = 0; i < 100; i++) begin
            if (MD_done) begin
                seen = 1'b1;
                stall_at_done = MD_stall;
                break;
            end
            if (MD_stall) stalls++;
            @(posedge clk);
            #1;
            EX_Rs_data = $urandom;
            EX_Rt_data = $urandom;
        end
        EX_MD_start = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        total++; if (MD_HI !== 32'h0) begin bad++; $display("FAIL reset_hi got=%h exp=%h", MD_HI, 32'h0); end
        total++; if (MD_LO !== 32'h0) begin bad++; $display("FAIL reset_lo got=%h exp=%h", MD_LO, 32'h0); end
        total++; if (MD_done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", MD_done); end
        total++; if (MD_stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b exp=0", MD_stall); end
    endtask

    task automatic test_multu();
        int st; bit seen; bit sd;
        run_op(2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, st, seen, sd);
        total++; if (!seen) begin bad++; $display("FAIL multu_timeout got=no_done exp=done"); end
        total++; if (st !== 34) begin bad++; $display("FAIL multu_stall_cycles got=%0d exp=34", st); end
        total++; if (sd !== 1'b0) begin bad++; $display("FAIL multu_stall_in_done got=%b exp=0", sd); end
        total++; if (MD_HI !== 32'hFFFFFFFE) begin bad++; $display("FAIL multu_hi got=%h exp=%h", MD_HI, 32'hFFFFFFFE); end
        total++; if (MD_LO !== 32'h00000001) begin bad++; $display("FAIL multu_lo got=%h exp=%h", MD_LO, 32'h00000001); end
        @(posedge clk); #1;
        total++; if (MD_done !== 1'b0) begin bad++; $display("FAIL multu_done_pulse got=%b exp=0", MD_done); end
        total++; if (MD_stall !== 1'b0) begin bad++; $display("FAIL multu_idle_stall got=%b exp=0", MD_stall); end
    endtask

    task automatic test_mult_signed();
        int st; bit seen; bit sd;
        run_op(2'd0, 32'hFFFFFFF9, 32'h00000003, st, seen, sd);
        total++; if (!seen) begin bad++; $display("FAIL mult_neg_timeout got=no_done exp=done"); end
        total++; if (MD_HI !== 32'hFFFFFFFF) begin bad++; $display("FAIL mult_neg_hi got=%h exp=%h", MD_HI, 32'hFFFFFFFF); end
        total++; if (MD_LO !== 32'hFFFFFFEB) begin bad++; $display("FAIL mult_neg_lo got=%h exp=%h", MD_LO, 32'hFFFFFFEB); end
        run_op(2'd0, 32'h80000000, 32'h80000000, st, seen, sd);
        total++; if (!seen) begin bad++; $display("FAIL mult_min_timeout got=no_done exp=done"); end
        total++; if (MD_HI !== 32'h40000000) begin bad++; $display("FAIL mult_min_hi got=%h exp=%h", MD_HI, 32'h40000000); end
        total++; if (MD_LO !== 32'h00000000) begin bad++; $display("FAIL mult_min_lo got=%h exp=%h", MD_LO, 32'h0); end
    endtask

    task automatic test_div();
        int st; bit seen; bit sd;
        run_op(2'd2, 32'hFFFFFFF9, 32'h00000002, st, seen, sd);
        total++; if (!seen) begin bad++; $display("FAIL div_neg_timeout got=no_done exp=done"); end
        total++; if (st !== 34) begin bad++; $display("FAIL div_stall_cycles got=%0d exp=34", st); end
        total++; if (MD_LO !== 32'hFFFFFFFD) begin bad++; $display("FAIL div_neg_lo got=%h exp=%h", MD_LO, 32'hFFFFFFFD); end
        total++; if (MD_HI !== 32'hFFFFFFFF) begin bad++; $display("FAIL div_neg_hi got=%h exp=%h", MD_HI, 32'hFFFFFFFF); end
        run_op(2'd3, 32'd100, 32'd7, st, seen, sd);
        total++; if (!seen) begin bad++; $display("FAIL divu_timeout got=no_done exp=done"); end
        total++; if (MD_LO !== 32'd14) begin bad++; $display("FAIL divu_lo got=%h exp=%h", MD_LO, 32'd14); end
        total++; if (MD_HI !== 32'd2) begin bad++; $display("FAIL divu_hi got=%h exp=%h", MD_HI, 32'd2); end
        run_op(2'd2, 32'h80000000, 32'hFFFFFFFF, st, seen, sd);
        total++; if (!seen) begin bad++; $display("FAIL div_wrap_timeout got=no_done exp=done"); end
        total++; if (MD_LO !== 32'h80000000) begin bad++; $display("FAIL div_wrap_lo got=%h exp=%h", MD_LO, 32'h80000000); end
        total++; if (MD_HI !== 32'h00000000) begin bad++; $display("FAIL div_wrap_hi got=%h exp=%h", MD_HI, 32'h0); end
    endtask

    task automatic test_div_zero();
        int st; bit seen; bit sd;
        run_op(2'd3, 32'd5, 32'd0, st, seen, sd);
        total++; if (!seen) begin bad++; $display("FAIL div0_timeout got=no_done exp=done"); end
        total++; if (st !== 2) begin bad++; $display("FAIL div0_stall_cycles got=%0d exp=2", st); end
        total++; if (MD_LO !== 32'hFFFFFFFF) begin bad++; $display("FAIL div0_lo got=%h exp=%h", MD_LO, 32'hFFFFFFFF); end
        total++; if (MD_HI !== 32'd5) begin bad++; $display("FAIL div0_hi got=%h exp=%h", MD_HI, 32'd5); end
    endtask

    task automatic test_start_wins();
        int st; bit seen; bit sd;
        EX_MtHi = 1'b1;
        EX_MtLo = 1'b1;
        run_op(2'd1, 32'd2, 32'd3, st, seen, sd);
        EX_MtHi = 1'b0;
        EX_MtLo = 1'b0;
        total++; if (!seen) begin bad++; $display("FAIL start_wins_timeout got=no_done exp=done"); end
        total++; if (MD_HI !== 32'd0) begin bad++; $display("FAIL start_wins_hi got=%h exp=%h", MD_HI, 32'd0); end
        total++; if (MD_LO !== 32'd6) begin bad++; $display("FAIL start_wins_lo got=%h exp=%h", MD_LO, 32'd6); end
        @(posedge clk);
        EX_Rs_data = 32'hCAFE0001;
        EX_MtLo = 1'b1;
        @(posedge clk);
        EX_MtLo = 1'b0;
        #1;
        total++; if (MD_LO !== 32'hCAFE0001) begin bad++; $display("FAIL mtlo_idle got=%h exp=%h", MD_LO, 32'hCAFE0001); end
        total++; if (MD_HI !== 32'd0) begin bad++; $display("FAIL mtlo_hi_kept got=%h exp=%h", MD_HI, 32'd0); end
    endtask

    task automatic test_back_to_back();
        int st; bit seen; bit sd;
        run_op(2'd0, 32'd6, 32'd7, st, seen, sd);
        total++; if (!seen) begin bad++; $display("FAIL b2b_timeout got=no_done exp=done"); end
        EX_MtHi = 1'b1;
        EX_Rs_data = 32'h00001234;
        @(posedge clk);
        EX_MtHi = 1'b0;
        #1;
        total++; if (MD_HI !== 32'h00001234) begin bad++; $display("FAIL b2b_mthi got=%h exp=%h", MD_HI, 32'h1234); end
        total++; if (MD_LO !== 32'h0000002A) begin bad++; $display("FAIL b2b_lo got=%h exp=%h", MD_LO, 32'h2A); end
    endtask

    task automatic test_reset_midop();
        int st; bit seen; bit sd;
        @(posedge clk);
        EX_MD_op = 2'd2;
        EX_Rs_data = 32'd1000;
        EX_Rt_data = 32'd3;
        EX_MD_start = 1'b1;
        repeat (11) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        total++; if (MD_HI !== 32'h0) begin bad++; $display("FAIL midrst_hi got=%h exp=%h", MD_HI, 32'h0); end
        total++; if (MD_LO !== 32'h0) begin bad++; $display("FAIL midrst_lo got=%h exp=%h", MD_LO, 32'h0); end
        total++; if (MD_done !== 1'b0) begin bad++; $display("FAIL midrst_done got=%b exp=0", MD_done); end
        total++; if (MD_stall !== 1'b1) begin bad++; $display("FAIL midrst_stall_start got=%b exp=1", MD_stall); end
        EX_MD_start = 1'b0;
        #1;
        total++; if (MD_stall !== 1'b0) begin bad++; $display("FAIL midrst_stall_idle got=%b exp=0", MD_stall); end
        @(posedge clk);
        rst = 1'b0;
        run_op(2'd3, 32'd1000, 32'd3, st, seen, sd);
        total++; if (!seen) begin bad++; $display("FAIL after_rst_timeout got=no_done exp=done"); end
        total++; if (st !== 34) begin bad++; $display("FAIL after_rst_stall_cycles got=%0d exp=34", st); end
        total++; if (MD_LO !== 32'd333) begin bad++; $display("FAIL after_rst_lo got=%h exp=%h", MD_LO, 32'd333); end
        total++; if (MD_HI !== 32'd1) begin bad++; $display("FAIL after_rst_hi got=%h exp=%h", MD_HI, 32'd1); end
    endtask

    initial begin
        rst = 1'b1;
        EX_MD_start = 1'b0;
        EX_MD_op = 2'd0;
        EX_MtHi = 1'b0;
        EX_MtLo = 1'b0;
        EX_Rs_data = 32'h0;
        EX_Rt_data = 32'h0;
        repeat (2) @(posedge clk);
        rst = 1'b0;
        test_reset();
        test_multu();
        test_mult_signed();
        test_div();
        test_div_zero();
        test_start_wins();
        test_back_to_back();
        test_reset_midop();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
